vsfx_issue_ctrl: RTL and testbench

Sequencer in front of the vsfx datapath (vaddsws/vsububm/vavgsh/vcmpequh/vslb lanes).
- Buffers issued vector ops in a small FIFO and drives the datapath one op at a time.
- Captures the result after a fixed latency and presents it on a valid/ready writeback port.
- Owns the sticky VSCR[SAT] bit and the CR6 update for record-form compares.

---
 rtl/vsfx_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_vsfx_issue_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsfx_issue_ctrl.sv
// Issue sequencer for the vsfx datapath: op FIFO, single-op-in-flight FSM,
// writeback port, sticky VSCR[SAT] and CR6 update. Optional perf counters: VSFX_CTRL_PERF_EN.
module vsfx_issue_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DP_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [7:0]         iss_ins,
  input  logic               iss_rc,
  input  logic [TAG_W-1:0]   iss_tag,
  input  logic [127:0]       iss_vra,
  input  logic [127:0]       iss_vrb,
  output logic               dp_en,
  output logic [7:0]         dp_ins,
  output logic [127:0]       dp_vra,
  output logic [127:0]       dp_vrb,
  input  logic [127:0]       dp_vrt,
  input  logic               dp_sat,
  input  logic [3:0]         dp_cr6,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [127:0]       wb_vrt,
  output logic [TAG_W-1:0]   wb_tag,
  output logic               wb_err,
  output logic               wb_cr6_en,
  output logic [3:0]         wb_cr6,
  output logic               vscr_sat,
`ifdef VSFX_CTRL_PERF_EN
  input  logic               vscr_sat_clr,
  output logic [31:0]        perf_ops,
  output logic [31:0]        perf_stall
`else
  input  logic               vscr_sat_clr
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  // Last WAIT count value; unused when DP_LAT == 1 (capture happens in ISSUE).
  localparam logic [2:0] WAIT_LAST = (DP_LAT > 1) ? 3'(DP_LAT - 2) : 3'd0;

  localparam logic [7:0] OP_VADDSWS  = 8'h70;
  localparam logic [7:0] OP_VCMPEQUH = 8'h0B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  state_t state, state_n;

  function automatic logic is_legal(input logic [7:0] op);
    case (op)
      8'h70, 8'h80, 8'hA9, 8'h0B, 8'h22: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  // ---------------- issue FIFO ----------------
  logic [7:0]       q_ins [DEPTH];
  logic             q_rc  [DEPTH];
  logic [TAG_W-1:0] q_tag [DEPTH];
  logic [127:0]     q_vra [DEPTH];
  logic [127:0]     q_vrb [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fifo_full, fifo_empty;
  logic          push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign iss_ready  = !fifo_full;
  assign push       = iss_valid && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      q_ins[wr_ptr[AW-1:0]] <= iss_ins;
      q_rc [wr_ptr[AW-1:0]] <= iss_rc;
      q_tag[wr_ptr[AW-1:0]] <= iss_tag;
      q_vra[wr_ptr[AW-1:0]] <= iss_vra;
      q_vrb[wr_ptr[AW-1:0]] <= iss_vrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- control FSM ----------------
  logic [2:0] wait_cnt;
  logic       capt;
  logic       ill_wb;
  logic       wb_hs;

  assign wb_hs = wb_valid && wb_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Popping on the edge that enters ISSUE lets the registered operands be
  // valid in the same cycle dp_en is high.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    capt    = 1'b0;
    ill_wb  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_n = S_ISSUE;
          pop     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!is_legal(dp_ins)) begin
          ill_wb  = 1'b1;
          state_n = S_WB;
        end else if (DP_LAT == 1) begin
          capt    = 1'b1;
          state_n = S_WB;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          capt    = 1'b1;
          state_n = S_WB;
        end
      end
      S_WB: begin
        if (wb_hs) begin
          if (!fifo_empty) begin
            state_n = S_ISSUE;
            pop     = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + 3'd1;
    else wait_cnt <= '0;
  end

  // ---------------- datapath drive ----------------
  logic             cur_rc;
  logic [TAG_W-1:0] cur_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_en   <= 1'b0;
      dp_ins  <= '0;
      dp_vra  <= '0;
      dp_vrb  <= '0;
      cur_rc  <= 1'b0;
      cur_tag <= '0;
    end else begin
      dp_en <= 1'b0;
      if (pop) begin
        dp_en   <= is_legal(q_ins[rd_ptr[AW-1:0]]);
        dp_ins  <= q_ins[rd_ptr[AW-1:0]];
        dp_vra  <= q_vra[rd_ptr[AW-1:0]];
        dp_vrb  <= q_vrb[rd_ptr[AW-1:0]];
        cur_rc  <= q_rc[rd_ptr[AW-1:0]];
        cur_tag <= q_tag[rd_ptr[AW-1:0]];
      end
    end
  end

  // ---------------- writeback / status ----------------
  logic cr6_hit;
  assign cr6_hit = (dp_ins == OP_VCMPEQUH) && cur_rc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_vrt    <= '0;
      wb_tag    <= '0;
      wb_err    <= 1'b0;
      wb_cr6_en <= 1'b0;
      wb_cr6    <= '0;
    end else if (capt) begin
      wb_valid  <= 1'b1;
      wb_vrt    <= dp_vrt;
      wb_tag    <= cur_tag;
      wb_err    <= 1'b0;
      wb_cr6_en <= cr6_hit;
      wb_cr6    <= cr6_hit ? dp_cr6 : 4'd0;
    end else if (ill_wb) begin
      wb_valid  <= 1'b1;
      wb_vrt    <= '0;
      wb_tag    <= cur_tag;
      wb_err    <= 1'b1;
      wb_cr6_en <= 1'b0;
      wb_cr6    <= '0;
    end else if (wb_hs) begin
      wb_valid  <= 1'b0;
    end
  end

  // Set has priority over an mtvscr clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            vscr_sat <= 1'b0;
    else if (capt && (dp_ins == OP_VADDSWS) && dp_sat)  vscr_sat <= 1'b1;
    else if (vscr_sat_clr)                              vscr_sat <= 1'b0;
  end

`ifdef VSFX_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (wb_hs)                  perf_ops   <= perf_ops + 32'd1;
      if (wb_valid && !wb_ready)  perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vsfx_issue_ctrl.sv
// Directed bench for vsfx_issue_ctrl: one instance with DP_LAT=1, one with DP_LAT=3.
module tb_vsfx_issue_ctrl;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst1, rst3;
  logic             iss_valid, iss_rc;
  logic [7:0]       iss_ins;
  logic [TAG_W-1:0] iss_tag;
  logic [127:0]     iss_vra, iss_vrb, dp_vrt;
  logic             dp_sat;
  logic [3:0]       dp_cr6;
  logic             wb_ready, vscr_sat_clr;

  logic             iss_ready1, dp_en1, wb_valid1, wb_err1, wb_cr6_en1, vscr_sat1;
  logic [7:0]       dp_ins1;
  logic [127:0]     dp_vra1, dp_vrb1, wb_vrt1;
  logic [TAG_W-1:0] wb_tag1;
  logic [3:0]       wb_cr6_1;

  logic             iss_ready3, dp_en3, wb_valid3, wb_err3, wb_cr6_en3, vscr_sat3;
  logic [7:0]       dp_ins3;
  logic [127:0]     dp_vra3, dp_vrb3, wb_vrt3;
  logic [TAG_W-1:0] wb_tag3;
  logic [3:0]       wb_cr6_3;

`ifdef VSFX_CTRL_PERF_EN
  logic [31:0] perf_ops1, perf_stall1, perf_ops3, perf_stall3;
`endif

  vsfx_issue_ctrl #(.DEPTH(4), .TAG_W(TAG_W), .DP_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .iss_valid(iss_valid), .iss_ready(iss_ready1), .iss_ins(iss_ins), .iss_rc(iss_rc),
    .iss_tag(iss_tag), .iss_vra(iss_vra), .iss_vrb(iss_vrb),
    .dp_en(dp_en1), .dp_ins(dp_ins1), .dp_vra(dp_vra1), .dp_vrb(dp_vrb1),
    .dp_vrt(dp_vrt), .dp_sat(dp_sat), .dp_cr6(dp_cr6),
    .wb_valid(wb_valid1), .wb_ready(wb_ready), .wb_vrt(wb_vrt1), .wb_tag(wb_tag1),
    .wb_err(wb_err1), .wb_cr6_en(wb_cr6_en1), .wb_cr6(wb_cr6_1),
    .vscr_sat(vscr_sat1),
`ifdef VSFX_CTRL_PERF_EN
    .perf_ops(perf_ops1), .perf_stall(perf_stall1),
`endif
    .vscr_sat_clr(vscr_sat_clr)
  );

  vsfx_issue_ctrl #(.DEPTH(4), .TAG_W(TAG_W), .DP_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .iss_valid(iss_valid), .iss_ready(iss_ready3), .iss_ins(iss_ins), .iss_rc(iss_rc),
    .iss_tag(iss_tag), .iss_vra(iss_vra), .iss_vrb(iss_vrb),
    .dp_en(dp_en3), .dp_ins(dp_ins3), .dp_vra(dp_vra3), .dp_vrb(dp_vrb3),
    .dp_vrt(dp_vrt), .dp_sat(dp_sat), .dp_cr6(dp_cr6),
    .wb_valid(wb_valid3), .wb_ready(wb_ready), .wb_vrt(wb_vrt3), .wb_tag(wb_tag3),
    .wb_err(wb_err3), .wb_cr6_en(wb_cr6_en3), .wb_cr6(wb_cr6_3),
    .vscr_sat(vscr_sat3),
`ifdef VSFX_CTRL_PERF_EN
    .perf_ops(perf_ops3), .perf_stall(perf_stall3),
`endif
    .vscr_sat_clr(vscr_sat_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [7:0] ins, input logic rc, input logic [TAG_W-1:0] tag,
                          input logic [127:0] vrt, input logic sat, input logic [3:0] cr6);
    iss_valid = 1'b1;
    iss_ins   = ins;
    iss_rc    = rc;
    iss_tag   = tag;
    dp_vrt    = vrt;
    dp_sat    = sat;
    dp_cr6    = cr6;
  endtask

  typedef struct {
    logic [7:0]       ins;
    logic             rc;
    logic [TAG_W-1:0] tag;
    logic [127:0]     vrt;
    logic             sat;
    logic [3:0]       cr6;
    logic             e_dp_en;
    logic             e_err;
    logic             e_cr6_en;
    logic [3:0]       e_cr6;
    logic [127:0]     e_vrt;
    logic             e_sat;
  } vec_t;

  localparam logic [127:0] V_SAT = {4{32'h7FFF_FFFF}};
  localparam logic [127:0] V_CMP = {4{32'h0000_FFFF}};
  localparam logic [127:0] V_A   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] V_B   = 128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444;

  vec_t vt[9];
  logic [TAG_W-1:0] got_tag[8];
  int               got;
  int               bad;
  logic [127:0]     vra_i, vrb_i;

  initial begin
    //        ins    rc  tag     vrt      sat cr6    dp_en err cr6en e_cr6 e_vrt  e_sat
    vt[0] = '{8'h70, 1'b0, 5'd3,  V_SAT,   1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, V_SAT,   1'b1};
    vt[1] = '{8'h0B, 1'b1, 5'd7,  V_CMP,   1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 4'h8, V_CMP,   1'b0};
    vt[2] = '{8'h0B, 1'b0, 5'd8,  V_CMP,   1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 4'h0, V_CMP,   1'b0};
    vt[3] = '{8'hFF, 1'b1, 5'd9,  V_A,     1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 4'h0, 128'd0,  1'b0};
    vt[4] = '{8'h80, 1'b1, 5'd10, V_A,     1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, V_A,     1'b0};
    vt[5] = '{8'hA9, 1'b0, 5'd11, V_B,     1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 4'h0, V_B,     1'b0};
    vt[6] = '{8'h22, 1'b0, 5'd31, ~V_A,    1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, ~V_A,    1'b0};
    vt[7] = '{8'h71, 1'b1, 5'd0,  V_B,     1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 4'h0, 128'd0,  1'b0};
    vt[8] = '{8'h0C, 1'b1, 5'd12, V_CMP,   1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h0, 128'd0,  1'b0};

    rst1 = 1'b1; rst3 = 1'b1;
    iss_valid = 1'b0; iss_rc = 1'b0; iss_ins = '0; iss_tag = '0;
    iss_vra = '0; iss_vrb = '0; dp_vrt = '0; dp_sat = 1'b0; dp_cr6 = '0;
    wb_ready = 1'b1; vscr_sat_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dp_en",     dp_en1,     1'b0);
    chk("rst_wb_valid",  wb_valid1,  1'b0);
    chk("rst_wb_err",    wb_err1,    1'b0);
    chk("rst_cr6_en",    wb_cr6_en1, 1'b0);
    chk("rst_vscr_sat",  vscr_sat1,  1'b0);
    chk("rst_wb_tag",    wb_tag1,    '0);
    chk("rst_wb_vrt",    wb_vrt1,    '0);
    chk("rst_dp_vra",    dp_vra1,    '0);
    rst1 = 1'b0;
    step();
    chk("rst_iss_ready", iss_ready1, 1'b1);

    // Table: one op at a time, sticky SAT cleared at the push edge.
    for (int i = 0; i < 9; i++) begin
      vra_i = {4{32'hA000_0000 | 32'(i)}};
      vrb_i = ~vra_i;
      drive_op(vt[i].ins, vt[i].rc, vt[i].tag, vt[i].vrt, vt[i].sat, vt[i].cr6);
      iss_vra = vra_i;
      iss_vrb = vrb_i;
      vscr_sat_clr = 1'b1;
      step();
      iss_valid = 1'b0;
      vscr_sat_clr = 1'b0;
      chk($sformatf("v%0d_idle_dp_en", i), dp_en1, 1'b0);
      chk($sformatf("v%0d_idle_wb_valid", i), wb_valid1, 1'b0);
      step();
      chk($sformatf("v%0d_dp_en", i), dp_en1, vt[i].e_dp_en);
      chk($sformatf("v%0d_dp_ins", i), dp_ins1, vt[i].ins);
      chk($sformatf("v%0d_dp_vra", i), dp_vra1, vra_i);
      chk($sformatf("v%0d_dp_vrb", i), dp_vrb1, vrb_i);
      step();
      chk($sformatf("v%0d_wb_valid", i), wb_valid1, 1'b1);
      chk($sformatf("v%0d_wb_tag", i), wb_tag1, vt[i].tag);
      chk($sformatf("v%0d_wb_vrt", i), wb_vrt1, vt[i].e_vrt);
      chk($sformatf("v%0d_wb_err", i), wb_err1, vt[i].e_err);
      chk($sformatf("v%0d_wb_cr6_en", i), wb_cr6_en1, vt[i].e_cr6_en);
      chk($sformatf("v%0d_wb_cr6", i), wb_cr6_1, vt[i].e_cr6);
      chk($sformatf("v%0d_vscr_sat", i), vscr_sat1, vt[i].e_sat);
      chk($sformatf("v%0d_dp_en_drop", i), dp_en1, 1'b0);
      step();
      chk($sformatf("v%0d_wb_release", i), wb_valid1, 1'b0);
    end

    // Sticky SAT survives a later non-saturating op.
    drive_op(8'h70, 1'b0, 5'd1, V_SAT, 1'b1, 4'h0);
    step(); iss_valid = 1'b0;
    step(); step();
    chk("sat_set", vscr_sat1, 1'b1);
    step();
    drive_op(8'h80, 1'b0, 5'd2, V_A, 1'b0, 4'h0);
    step(); iss_valid = 1'b0;
    step(); step(); step();
    chk("sat_sticky", vscr_sat1, 1'b1);

    // Clear coinciding with a saturating capture: set wins; clear alone then clears.
    drive_op(8'h70, 1'b0, 5'd4, V_SAT, 1'b1, 4'h0);
    vscr_sat_clr = 1'b1;
    step(); iss_valid = 1'b0;
    chk("sat_clr_idle", vscr_sat1, 1'b0);
    step();
    step();
    chk("sat_set_wins", vscr_sat1, 1'b1);
    step();
    chk("sat_clr_alone", vscr_sat1, 1'b0);
    vscr_sat_clr = 1'b0;

    // Fill with writeback stalled: 5 accepted, 6th refused, drained in order.
    wb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_op(8'h80, 1'b0, TAG_W'(10 + i), V_B, 1'b0, 4'h0);
      step();
      if (i == 3) chk("fifo_not_full_3", iss_ready1, 1'b1);
      if (i == 4) chk("fifo_full_5", iss_ready1, 1'b0);
    end
    iss_valid = 1'b0;
    chk("fifo_refused_6", iss_ready1, 1'b0);
    chk("stall_wb_valid", wb_valid1, 1'b1);
    chk("stall_wb_tag", wb_tag1, 5'd10);
    wb_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (wb_valid1) begin
        if (got < 8) got_tag[got] = wb_tag1;
        got++;
      end
      step();
    end
    chk("drain_count", 128'(got), 128'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got) chk($sformatf("drain_tag%0d", i), got_tag[i], TAG_W'(10 + i));
    end
    chk("drain_iss_ready", iss_ready1, 1'b1);

    // DP_LAT=3 instance: latency, then reset while in WAIT.
    rst3 = 1'b0;
    chk("l3_rst_iss_ready", iss_ready3, 1'b1);
    chk("l3_rst_wb_valid", wb_valid3, 1'b0);
    drive_op(8'h70, 1'b0, 5'd19, V_B, 1'b0, 4'h0);
    step(); iss_valid = 1'b0;
    step();
    chk("l3_dp_en", dp_en3, 1'b1);
    step();
    chk("l3_wait1_dp_en", dp_en3, 1'b0);
    chk("l3_wait1_valid", wb_valid3, 1'b0);
    step();
    chk("l3_wait2_valid", wb_valid3, 1'b0);
    step();
    chk("l3_wb_valid", wb_valid3, 1'b1);
    chk("l3_wb_tag", wb_tag3, 5'd19);
    chk("l3_wb_vrt", wb_vrt3, V_B);
    step();
    chk("l3_wb_release", wb_valid3, 1'b0);

    for (int i = 0; i < 3; i++) begin
      drive_op(8'h80, 1'b0, TAG_W'(20 + i), V_A, 1'b0, 4'h0);
      step();
    end
    iss_valid = 1'b0;
    chk("l3_in_wait_dp_en", dp_en3, 1'b0);
    rst3 = 1'b1;
    #2;
    chk("l3_rst_mid_valid", wb_valid3, 1'b0);
    chk("l3_rst_mid_ready", iss_ready3, 1'b1);
    step();
    rst3 = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (wb_valid3 || dp_en3) bad++;
      step();
    end
    chk("l3_no_wb_after_rst", 128'(bad), 128'd0);
    chk("l3_after_rst_ready", iss_ready3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
